// File: rtl/img_proc_pkg.sv
// img_proc_pkg: types and helpers shared by the RGB video-path stages.
package img_proc_pkg;
  typedef enum logic [1:0] {LUT_R, LUT_G, LUT_B, LUT_ALL} lut_ch_t;
  localparam int AXIS_ID_W   = 4;
  localparam int AXIS_DEST_W = 4;
  function automatic int tdata_width(input int px_w);
    return ((3 * px_w + 7) / 8) * 8;
  endfunction
endpackage

// File: rtl/axi4_stream_if.sv
// axi4_stream_if: AXI4-Stream bundle used between the video stages.
interface axi4_stream_if
  import img_proc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) ();
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;
  logic                    tuser;
  logic [AXIS_ID_W-1:0]    tid;
  logic [AXIS_DEST_W-1:0]  tdest;
  modport master(output tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest, input tready);
  modport slave(input tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest, output tready);
endinterface

// File: rtl/gamma_lut_ram.sv
// gamma_lut_ram: simple dual-port LUT RAM, registered read-first output for block-RAM inference.
module gamma_lut_ram #(
  parameter int AW = 10,
  parameter int DW = 10
) (
  input  logic          clk_i,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);
  logic [DW-1:0] r_mem [2**AW];
  always_ff @(posedge clk_i) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end
endmodule

// File: rtl/gamma_corrector.sv
// gamma_corrector: per-channel gamma LUT stage on the RGB AXI4-Stream path, 2-cycle latency.
module gamma_corrector
  import img_proc_pkg::*;
#(
  parameter int PX_WIDTH = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                lut_wr_i,
  input  logic [1:0]          lut_ch_i,
  input  logic [PX_WIDTH-1:0] lut_addr_i,
  input  logic [PX_WIDTH-1:0] lut_data_i,
  input  logic                bypass_i,
  axi4_stream_if.slave        video_i,
  axi4_stream_if.master       video_o
);
  localparam int TDATA_WIDTH = tdata_width(PX_WIDTH);
  localparam int KW = TDATA_WIDTH / 8;
  logic                     w_en;
  logic [2:0][PX_WIDTH-1:0] w_in;
  logic [2:0][PX_WIDTH-1:0] w_res;
  logic [PX_WIDTH-1:0]      w_lut [3];
  logic                     r_s1_valid, r_s1_last, r_s1_user, r_s1_byp;
  logic [KW-1:0]            r_s1_keep, r_s1_strb;
  logic [AXIS_ID_W-1:0]     r_s1_id;
  logic [AXIS_DEST_W-1:0]   r_s1_dest;
  logic [2:0][PX_WIDTH-1:0] r_s1_px;
  logic                     r_o_valid, r_o_last, r_o_user;
  logic [TDATA_WIDTH-1:0]   r_o_data;
  logic [KW-1:0]            r_o_keep, r_o_strb;
  logic [AXIS_ID_W-1:0]     r_o_id;
  logic [AXIS_DEST_W-1:0]   r_o_dest;
  // Whole pipeline, RAM read ports included, freezes on stall so RAM data stays aligned.
  assign w_en = !r_o_valid || video_o.tready;
  assign video_i.tready = w_en;
  assign w_in[0] = video_i.tdata[3*PX_WIDTH-1:2*PX_WIDTH];
  assign w_in[1] = video_i.tdata[PX_WIDTH-1:0];
  assign w_in[2] = video_i.tdata[2*PX_WIDTH-1:PX_WIDTH];
  for (genvar c = 0; c < 3; c++) begin : g_ch
    gamma_lut_ram #(.AW(PX_WIDTH), .DW(PX_WIDTH)) u_ram (
      .clk_i     (clk_i),
      .i_wr_en   (lut_wr_i && (lut_ch_i == 2'(c) || lut_ch_i == LUT_ALL)),
      .i_wr_addr (lut_addr_i),
      .i_wr_data (lut_data_i),
      .i_rd_en   (w_en),
      .i_rd_addr (w_in[c]),
      .o_rd_data (w_lut[c])
    );
    assign w_res[c] = r_s1_byp ? r_s1_px[c] : w_lut[c];
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_user  <= 1'b0;
      r_s1_byp   <= 1'b0;
      r_s1_keep  <= '0;
      r_s1_strb  <= '0;
      r_s1_id    <= '0;
      r_s1_dest  <= '0;
      r_s1_px    <= '0;
      r_o_valid  <= 1'b0;
      r_o_last   <= 1'b0;
      r_o_user   <= 1'b0;
      r_o_data   <= '0;
      r_o_keep   <= '0;
      r_o_strb   <= '0;
      r_o_id     <= '0;
      r_o_dest   <= '0;
    end else if (w_en) begin
      r_s1_valid <= video_i.tvalid;
      r_s1_last  <= video_i.tlast;
      r_s1_user  <= video_i.tuser;
      r_s1_byp   <= bypass_i;
      r_s1_keep  <= video_i.tkeep;
      r_s1_strb  <= video_i.tstrb;
      r_s1_id    <= video_i.tid;
      r_s1_dest  <= video_i.tdest;
      r_s1_px    <= w_in;
      r_o_valid  <= r_s1_valid;
      r_o_last   <= r_s1_last;
      r_o_user   <= r_s1_user;
      r_o_data   <= TDATA_WIDTH'({w_res[0], w_res[2], w_res[1]});
      r_o_keep   <= r_s1_keep;
      r_o_strb   <= r_s1_strb;
      r_o_id     <= r_s1_id;
      r_o_dest   <= r_s1_dest;
    end
  end
  assign video_o.tvalid = r_o_valid;
  assign video_o.tdata  = r_o_data;
  assign video_o.tlast  = r_o_last;
  assign video_o.tuser  = r_o_user;
  assign video_o.tkeep  = r_o_keep;
  assign video_o.tstrb  = r_o_strb;
  assign video_o.tid    = r_o_id;
  assign video_o.tdest  = r_o_dest;
endmodule

// File: tb/tb_gamma_corrector.sv
// tb_gamma_corrector: random/directed stimulus against a LUT-array scoreboard model.
module tb_gamma_corrector;
  import img_proc_pkg::*;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic lut_wr_i = 1'b0;
  logic [1:0] lut_ch_i = 2'd0;
  logic [9:0] lut_addr_i = '0, lut_data_i = '0;
  logic bypass_i = 1'b0;
  always #5 clk_i = ~clk_i;
  axi4_stream_if #(.DATA_WIDTH(32)) vin ();
  axi4_stream_if #(.DATA_WIDTH(32)) vout ();
  gamma_corrector #(.PX_WIDTH(10)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .lut_wr_i(lut_wr_i), .lut_ch_i(lut_ch_i),
    .lut_addr_i(lut_addr_i), .lut_data_i(lut_data_i), .bypass_i(bypass_i),
    .video_i(vin), .video_o(vout)
  );
  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  typedef struct {
    logic [31:0] d;
    logic        last, user;
    logic [3:0]  keep, strb, id, dest;
    int          t;
  } beat_t;
  logic [9:0] m_lut [3][1024];
  beat_t q[$];
  int cyc = 0, n_out = 0;
  bit chk_lat = 0, rdy_rand = 0, hold_lo = 0;
  logic [31:0] last_out = '0;
  function automatic logic [31:0] pk(input logic [9:0] r, g, b);
    return {2'b00, r, b, g};
  endfunction
  // Golden model: index each channel's table array, or pass through on bypass.
  function automatic logic [31:0] model(input logic [31:0] d, input logic byp);
    logic [9:0] r, g, b;
    r = d[29:20]; b = d[19:10]; g = d[9:0];
    if (!byp) begin
      r = m_lut[0][r]; g = m_lut[1][g]; b = m_lut[2][b];
    end
    return pk(r, g, b);
  endfunction
  always @(negedge clk_i) begin
    beat_t e;
    cyc++;
    if (rst_i) q.delete();
    else begin
      if (vout.tvalid) begin
        if (q.size() == 0) check("spurious_beat", 64'(vout.tdata), 64'hDEAD_BEEF_0000);
        else begin
          check("tdata", 64'(vout.tdata), 64'(q[0].d));
          check("tlast", 64'(vout.tlast), 64'(q[0].last));
          check("tuser", 64'(vout.tuser), 64'(q[0].user));
          check("tkeep_tstrb", 64'({vout.tkeep, vout.tstrb}), 64'({q[0].keep, q[0].strb}));
          check("tid_tdest", 64'({vout.tid, vout.tdest}), 64'({q[0].id, q[0].dest}));
          if (vout.tready) begin
            if (chk_lat) check("latency", 64'(cyc - q[0].t), 64'd2);
            last_out = vout.tdata;
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (vin.tvalid && vin.tready) begin
        e.d = model(vin.tdata, bypass_i);
        e.last = vin.tlast; e.user = vin.tuser; e.keep = vin.tkeep; e.strb = vin.tstrb;
        e.id = vin.tid; e.dest = vin.tdest; e.t = cyc;
        q.push_back(e);
      end
      if (lut_wr_i)
        for (int c = 0; c < 3; c++)
          if (lut_ch_i == 2'(c) || lut_ch_i == 2'd3) m_lut[c][lut_addr_i] = lut_data_i;
    end
  end
  always @(posedge clk_i) begin
    #1;
    vout.tready = hold_lo ? 1'b0 : (rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1);
  end
  task automatic tick();
    @(posedge clk_i); #1;
  endtask
  task automatic load(input int ch, input int mode);
    for (int i = 0; i < 1024; i++) begin
      lut_wr_i = 1'b1; lut_ch_i = 2'(ch); lut_addr_i = 10'(i);
      lut_data_i = mode == 0 ? 10'(i) : mode == 1 ? 10'(1023 - i) : mode == 2 ? 10'd5 : 10'($urandom);
      tick();
    end
    lut_wr_i = 1'b0;
  endtask
  task automatic send(input logic [31:0] d, input logic u, input logic l, input logic b);
    vin.tvalid = 1'b1; vin.tdata = d; vin.tuser = u; vin.tlast = l; bypass_i = b;
    vin.tkeep = 4'($urandom); vin.tstrb = 4'($urandom);
    vin.tid = 4'($urandom); vin.tdest = 4'($urandom);
    for (int k = 0; ; k++) begin
      @(negedge clk_i);
      if (vin.tready) break;
      if (k > 500) begin
        check("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    tick();
    vin.tvalid = 1'b0;
  endtask
  task automatic drain();
    for (int k = 0; q.size() != 0; k++) begin
      if (k > 500) begin
        check("drain_timeout", 64'(q.size()), 64'd0);
        q.delete();
        break;
      end
      tick();
    end
    tick(); tick();
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int t0;
    vin.tvalid = 0; vin.tdata = 0; vin.tuser = 0; vin.tlast = 0;
    vin.tkeep = 0; vin.tstrb = 0; vin.tid = 0; vin.tdest = 0;
    repeat (3) tick();
    check("rst_tvalid", 64'(vout.tvalid), 64'd0);
    check("rst_tdata", 64'(vout.tdata), 64'd0);
    check("rst_sideband", 64'({vout.tlast, vout.tuser, vout.tkeep, vout.tstrb, vout.tid, vout.tdest}), 64'd0);
    rst_i = 1'b0;
    tick();
    check("tready_after_rst", 64'(vin.tready), 64'd1);
    // identity tables, back-to-back line with latency tracking
    load(3, 0);
    chk_lat = 1;
    t0 = cyc;
    for (int i = 0; i < 64; i++)
      send(pk(10'(i), 10'(i + 1), 10'(i + 2)), i == 0, i == 63, 1'b0);
    check("throughput_cycles", 64'(cyc - t0), 64'd64);
    drain();
    chk_lat = 0;
    check("identity_last", 64'(last_out), 64'(pk(10'd63, 10'd64, 10'd65)));
    // inverted red table
    load(0, 1);
    send(pk(10'd100, 10'd200, 10'd300), 1'b1, 1'b1, 1'b0);
    drain();
    check("invert_red", 64'(last_out), 64'(pk(10'd923, 10'd200, 10'd300)));
    check("pad_bits", 64'(last_out[31:30]), 64'd0);
    // random tables, random valid/ready over a 32x4 frame
    load(0, 3); load(1, 3); load(2, 3);
    rdy_rand = 1;
    for (int ln = 0; ln < 4; ln++)
      for (int p = 0; p < 32; p++) begin
        while ($urandom_range(2, 0) == 0) tick();
        send($urandom, ln == 0 && p == 0, p == 31, 1'b0);
      end
    drain();
    rdy_rand = 0;
    // bypass toggled mid-line over a constant table
    load(3, 2);
    for (int i = 0; i < 16; i++) send($urandom, i == 0, i == 15, i >= 5 && i < 11);
    drain();
    // read-first collision, then a broadcast write
    load(3, 0);
    lut_wr_i = 1'b1; lut_ch_i = 2'd0; lut_addr_i = 10'd7; lut_data_i = 10'd99;
    send(pk(10'd7, 10'd0, 10'd0), 1'b1, 1'b0, 1'b0);
    lut_wr_i = 1'b0;
    drain();
    check("collision_old", 64'(last_out), 64'(pk(10'd7, 10'd0, 10'd0)));
    send(pk(10'd7, 10'd0, 10'd0), 1'b0, 1'b1, 1'b0);
    drain();
    check("collision_new", 64'(last_out), 64'(pk(10'd99, 10'd0, 10'd0)));
    lut_wr_i = 1'b1; lut_ch_i = 2'd3; lut_addr_i = 10'd8; lut_data_i = 10'd77;
    tick();
    lut_wr_i = 1'b0;
    send(pk(10'd8, 10'd8, 10'd8), 1'b1, 1'b1, 1'b0);
    drain();
    check("write_all", 64'(last_out), 64'(pk(10'd77, 10'd77, 10'd77)));
    // reset with two beats stuck in the pipe
    hold_lo = 1;
    tick();
    send(pk(10'd1, 10'd2, 10'd3), 1'b1, 1'b0, 1'b0);
    send(pk(10'd4, 10'd5, 10'd6), 1'b0, 1'b0, 1'b0);
    tick();
    check("stall_tvalid", 64'(vout.tvalid), 64'd1);
    rst_i = 1'b1;
    #1;
    check("async_rst_tvalid", 64'(vout.tvalid), 64'd0);
    check("async_rst_tdata", 64'(vout.tdata), 64'd0);
    tick();
    rst_i = 1'b0;
    hold_lo = 0;
    tick();
    for (int i = 0; i < 16; i++) send(pk(10'(i * 3), 10'(i * 5), 10'(i * 7)), i == 0, i == 15, 1'b0);
    drain();
    check("post_rst_last", 64'(last_out), 64'(pk(10'd45, 10'd75, 10'd105)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
